// File: rtl/next_pc_ctx.sv
// Next-fetch-address generator with a round-robin saved-PC table for NPROC user programs.
// Redirects to the kernel on a context-change edge or program exit, and resumes programs on dispatch.
module next_pc_ctx #(
  parameter int          NPROC       = 4,
  parameter int          PID_W       = 2,
  parameter logic [31:0] OS_ENTRY    = 32'h0000_0000,
  parameter logic [31:0] PROG_BASE   = 32'h0000_1000,
  parameter logic [31:0] PROG_STRIDE = 32'h0000_1000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      pc_current,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             ctx_change,
  input  logic             proc_done,
  input  logic             sched_go,
  input  logic             proc_load,
  input  logic [PID_W-1:0] proc_load_id,
  input  logic [31:0]      proc_load_pc,
  output logic [31:0]      next_pc,
  output logic             in_program,
  output logic [PID_W-1:0] cur_proc,
  output logic             idle
);

  typedef enum logic {KERNEL, RUN} stateT;

  stateT             state;
  logic [NPROC-1:0]  valid;
  logic [31:0]       savedPc [NPROC];
  logic              ctxD;

  logic [31:0]       seqPc;
  logic              ctxEv;
  logic              found;
  logic [PID_W-1:0]  sel;

  always_comb begin
    if (jump)
      seqPc = jump_target;
    else if (branch_taken)
      seqPc = branch_target;
    else
      seqPc = pc_current + 32'd4;
  end

  assign ctxEv = ctx_change & ~ctxD & (state == RUN);

  // Round-robin scan starting just after the last-run slot; that slot itself is tried last.
  always_comb begin
    int               cand;
    logic [PID_W-1:0] candId;
    found  = 1'b0;
    sel    = cur_proc;
    cand   = 0;
    candId = '0;
    for (int k = 1; k <= NPROC; k++) begin
      cand   = (int'(cur_proc) + k) % NPROC;
      candId = PID_W'(cand);
      if (!found && valid[candId]) begin
        found = 1'b1;
        sel   = candId;
      end
    end
  end

  always_comb begin
    next_pc = seqPc;
    if (state == RUN) begin
      if (proc_done || ctxEv)
        next_pc = OS_ENTRY;
    end else if (sched_go && found) begin
      next_pc = savedPc[sel];
    end
  end

  // proc_load sits after the save/retire updates so its write wins on the same slot.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= KERNEL;
      in_program <= 1'b0;
      cur_proc   <= PID_W'(NPROC - 1);
      idle       <= 1'b0;
      valid      <= '0;
      ctxD       <= 1'b0;
      for (int i = 0; i < NPROC; i++)
        savedPc[i] <= PROG_BASE + 32'(i) * PROG_STRIDE;
    end else begin
      ctxD <= ctx_change;
      case (state)
        RUN: begin
          if (proc_done) begin
            valid[cur_proc] <= 1'b0;
            state           <= KERNEL;
            in_program      <= 1'b0;
          end else if (ctxEv) begin
            savedPc[cur_proc] <= pc_current;
            state             <= KERNEL;
            in_program        <= 1'b0;
          end
        end
        KERNEL: begin
          if (sched_go) begin
            if (found) begin
              cur_proc   <= sel;
              state      <= RUN;
              in_program <= 1'b1;
              idle       <= 1'b0;
            end else begin
              idle <= 1'b1;
            end
          end
        end
        default: state <= KERNEL;
      endcase
      if (proc_load) begin
        savedPc[proc_load_id] <= proc_load_pc;
        valid[proc_load_id]   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_ctx.sv
// Directed, table-driven bench for next_pc_ctx: each row is one cycle of inputs plus the
// outputs expected mid-cycle (next_pc combinational, the rest from earlier edges).
module tb_next_pc_ctx;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        ctx_change;
  logic        proc_done;
  logic        sched_go;
  logic        proc_load;
  logic [1:0]  proc_load_id;
  logic [31:0] proc_load_pc;
  logic [31:0] next_pc;
  logic        in_program;
  logic [1:0]  cur_proc;
  logic        idle;

  int compareCount  = 0;
  int mismatchCount = 0;

  next_pc_ctx dut (
    .CLK          (CLK),
    .reset        (reset),
    .pc_current   (pc_current),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .ctx_change   (ctx_change),
    .proc_done    (proc_done),
    .sched_go     (sched_go),
    .proc_load    (proc_load),
    .proc_load_id (proc_load_id),
    .proc_load_pc (proc_load_pc),
    .next_pc      (next_pc),
    .in_program   (in_program),
    .cur_proc     (cur_proc),
    .idle         (idle)
  );

  always #5 CLK = ~CLK;

  // ctrl bits: [5]=jump [4]=branch_taken [3]=ctx_change [2]=proc_done [1]=sched_go [0]=proc_load
  typedef struct {
    logic [31:0] pcCur;
    logic [5:0]  ctrl;
    logic [31:0] jmpT;
    logic [31:0] brT;
    logic [1:0]  ldId;
    logic [31:0] ldPc;
    logic [31:0] expNext;
    logic        expIn;
    logic [1:0]  expCur;
    logic        expIdle;
  } vecT;

  vecT vec[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input vecT v);
    pc_current    = v.pcCur;
    jump          = v.ctrl[5];
    branch_taken  = v.ctrl[4];
    ctx_change    = v.ctrl[3];
    proc_done     = v.ctrl[2];
    sched_go      = v.ctrl[1];
    proc_load     = v.ctrl[0];
    jump_target   = v.jmpT;
    branch_target = v.brT;
    proc_load_id  = v.ldId;
    proc_load_pc  = v.ldPc;
  endtask

  task automatic checkAll(input string tag, input vecT v);
    checkOutput({tag, " next_pc"}, next_pc, v.expNext);
    checkOutput({tag, " in_program"}, 32'(in_program), 32'(v.expIn));
    checkOutput({tag, " cur_proc"}, 32'(cur_proc), 32'(v.expCur));
    checkOutput({tag, " idle"}, 32'(idle), 32'(v.expIdle));
  endtask

  task automatic applyStimulus(input vecT v, input string tag);
    @(negedge CLK);
    driveInputs(v);
    #1;
    checkAll(tag, v);
  endtask

  initial begin
    vecT v;
    reset = 1'b1;
    driveInputs('{32'h0000_0100, 6'b000000, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0});
    #1;
    checkAll("reset", '{32'h0, 6'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0000_0104, 1'b0, 2'd3, 1'b0});
    @(negedge CLK);
    reset = 1'b0;

    //           pcCur          ctrl       jmpT          brT           id    ldPc          expNext       in    cur   idle
    vec.push_back('{32'h0000_0100, 6'b000001, 32'h0,        32'h0,        2'd0, 32'h0000_2000, 32'h0000_0104, 1'b0, 2'd3, 1'b0});
    vec.push_back('{32'h0000_0104, 6'b000001, 32'h0,        32'h0,        2'd2, 32'h0000_3000, 32'h0000_0108, 1'b0, 2'd3, 1'b0});
    vec.push_back('{32'h0000_0108, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_2000, 1'b0, 2'd3, 1'b0});
    vec.push_back('{32'h0000_2000, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_2004, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_2010, 6'b001000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0000, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_0000, 6'b001000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0004, 1'b0, 2'd0, 1'b0});
    vec.push_back('{32'h0000_0004, 6'b001000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0008, 1'b0, 2'd0, 1'b0});
    vec.push_back('{32'h0000_0008, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_3000, 1'b0, 2'd0, 1'b0});
    vec.push_back('{32'h0000_3000, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_3004, 1'b1, 2'd2, 1'b0});
    vec.push_back('{32'h0000_3004, 6'b001100, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0000, 1'b1, 2'd2, 1'b0});
    vec.push_back('{32'h0000_0000, 6'b001010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_2010, 1'b0, 2'd2, 1'b0});
    vec.push_back('{32'hFFFF_FFFC, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0000, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_2020, 6'b110000, 32'h0000_5000, 32'h0000_6000, 2'd0, 32'h0,       32'h0000_5000, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_2024, 6'b010000, 32'h0,        32'h0000_6000, 2'd0, 32'h0,        32'h0000_6000, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_2028, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_202C, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_202C, 6'b000100, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0000, 1'b1, 2'd0, 1'b0});
    vec.push_back('{32'h0000_0040, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0044, 1'b0, 2'd0, 1'b0});
    vec.push_back('{32'h0000_0044, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0048, 1'b0, 2'd0, 1'b1});
    vec.push_back('{32'h0000_0048, 6'b000001, 32'h0,        32'h0,        2'd1, 32'h0000_7000, 32'h0000_004C, 1'b0, 2'd0, 1'b1});
    vec.push_back('{32'h0000_004C, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_7000, 1'b0, 2'd0, 1'b1});
    vec.push_back('{32'h0000_7000, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_7004, 1'b1, 2'd1, 1'b0});
    vec.push_back('{32'h0000_7004, 6'b000001, 32'h0,        32'h0,        2'd1, 32'h0000_8000, 32'h0000_7008, 1'b1, 2'd1, 1'b0});
    vec.push_back('{32'h0000_7008, 6'b001001, 32'h0,        32'h0,        2'd3, 32'h0000_9000, 32'h0000_0000, 1'b1, 2'd1, 1'b0});
    vec.push_back('{32'h0000_0000, 6'b001011, 32'h0,        32'h0,        2'd3, 32'h0000_A000, 32'h0000_9000, 1'b0, 2'd1, 1'b0});
    vec.push_back('{32'h0000_9000, 6'b001000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_9004, 1'b1, 2'd3, 1'b0});
    vec.push_back('{32'h0000_9004, 6'b001100, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_0000, 1'b1, 2'd3, 1'b0});
    vec.push_back('{32'h0000_0000, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_7008, 1'b0, 2'd3, 1'b0});
    vec.push_back('{32'h0000_7008, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_700C, 1'b1, 2'd1, 1'b0});
    vec.push_back('{32'h0000_700C, 6'b000101, 32'h0,        32'h0,        2'd1, 32'h0000_B000, 32'h0000_0000, 1'b1, 2'd1, 1'b0});
    vec.push_back('{32'h0000_0010, 6'b000010, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_B000, 1'b0, 2'd1, 1'b0});
    vec.push_back('{32'h0000_B000, 6'b000000, 32'h0,        32'h0,        2'd0, 32'h0,         32'h0000_B004, 1'b1, 2'd1, 1'b0});

    foreach (vec[i])
      applyStimulus(vec[i], $sformatf("row%0d", i));

    // Asynchronous reset mid-run with a table write pending on the running slot.
    @(negedge CLK);
    driveInputs('{32'h0000_B004, 6'b000001, 32'h0, 32'h0, 2'd1, 32'h0000_C000, 32'h0, 1'b0, 2'd0, 1'b0});
    #1 reset = 1'b1;
    #1;
    checkAll("asyncReset", '{32'h0, 6'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0000_B008, 1'b0, 2'd3, 1'b0});
    @(negedge CLK);
    reset = 1'b0;
    driveInputs('{32'h0000_0020, 6'b000000, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0});

    v = '{32'h0000_0020, 6'b000010, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0000_0024, 1'b0, 2'd3, 1'b0};
    applyStimulus(v, "postReset go");
    v = '{32'h0000_0024, 6'b000000, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0000_0028, 1'b0, 2'd3, 1'b1};
    applyStimulus(v, "postReset idle");

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
